// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the UDP transmit path (scheduler and frame sender).
package udp_tx_pkg;

  localparam int LEN_W       = 16;
  localparam int PORT_W      = 16;
  localparam int DEF_MIN_LEN = 32;
  localparam int DEF_MAX_LEN = 1472;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } sched_state_e;

  // Unsigned 16-bit inclusive range check on a payload length.
  function automatic logic len_ok(input logic [LEN_W-1:0] len,
                                  input int unsigned min_len,
                                  input int unsigned max_len);
    return (len >= LEN_W'(min_len)) && (len <= LEN_W'(max_len));
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] index
);

  logic [IW:0] pos;

  // Walk offsets from farthest to nearest so the closest request to ptr is written last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (req[pos[IW-1:0]]) begin
        valid = 1'b1;
        index = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Round-robin scheduler sharing one UDP frame sender: length check, single-cycle start,
// watchdog on completion and an enforced inter-frame gap before the next grant.
module udp_tx_scheduler
  import udp_tx_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MIN_LEN    = DEF_MIN_LEN,
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int IFG_CYCLES = 12,
  parameter int TIMEOUT    = 4095,
  localparam int SEL_W     = $clog2(NUM_REQ),
  localparam int WD_W      = $clog2(TIMEOUT + 1),
  localparam int GAP_W     = $clog2(IFG_CYCLES + 1)
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*PORT_W-1:0] req_port,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic                      tx_start,
  output logic [LEN_W-1:0]          tx_len,
  output logic [PORT_W-1:0]         tx_port,
  output logic [SEL_W-1:0]          src_sel,
  input  logic                      tx_done,
  output logic [31:0]               frame_cnt
);

  sched_state_e state, state_d;
  logic [SEL_W-1:0]   ptr, ptr_d;
  logic [WD_W-1:0]    wdog, wdog_d;
  logic [GAP_W-1:0]   gap_cnt, gap_d;
  logic [NUM_REQ-1:0] grant_d, done_d, err_d;
  logic               start_d;
  logic [LEN_W-1:0]   len_d;
  logic [PORT_W-1:0]  port_d;
  logic [SEL_W-1:0]   sel_d;
  logic [31:0]        cnt_d;

  logic               pick_valid;
  logic [SEL_W-1:0]   pick_idx;
  logic [LEN_W-1:0]   pick_len;
  logic [PORT_W-1:0]  pick_port;
  logic               pick_ok;
  logic               wd_expired;
  logic               gap_last;

  rr_pick #(.N(NUM_REQ), .IW(SEL_W)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign pick_len   = req_len[pick_idx*LEN_W +: LEN_W];
  assign pick_port  = req_port[pick_idx*PORT_W +: PORT_W];
  assign pick_ok    = len_ok(pick_len, MIN_LEN, MAX_LEN);
  assign wd_expired = (wdog == WD_W'(TIMEOUT - 1));
  assign gap_last   = (gap_cnt == GAP_W'(IFG_CYCLES - 1));

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (pick_valid && pick_ok) state_d = SEND;
      SEND:    if (tx_done || wd_expired) state_d = GAP;
      GAP:     if (gap_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed here as next values; tx_done beats the watchdog.
  always_comb begin
    grant_d = grant;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    len_d   = tx_len;
    port_d  = tx_port;
    sel_d   = src_sel;
    cnt_d   = frame_cnt;
    ptr_d   = ptr;
    wdog_d  = '0;
    gap_d   = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          ptr_d = (pick_idx == SEL_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          if (pick_ok) begin
            grant_d           = '0;
            grant_d[pick_idx] = 1'b1;
            start_d           = 1'b1;
            len_d             = pick_len;
            port_d            = pick_port;
            sel_d             = pick_idx;
          end else begin
            err_d[pick_idx] = 1'b1;
          end
        end
      end
      SEND: begin
        wdog_d = wdog + 1'b1;
        if (tx_done) begin
          done_d[src_sel] = 1'b1;
          grant_d         = '0;
          cnt_d           = frame_cnt + 32'd1;
        end else if (wd_expired) begin
          err_d[src_sel] = 1'b1;
          grant_d        = '0;
        end
      end
      GAP: gap_d = gap_cnt + 1'b1;
      default: grant_d = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      wdog      <= '0;
      gap_cnt   <= '0;
      grant     <= '0;
      done      <= '0;
      err       <= '0;
      tx_start  <= 1'b0;
      tx_len    <= '0;
      tx_port   <= '0;
      src_sel   <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      wdog      <= wdog_d;
      gap_cnt   <= gap_d;
      grant     <= grant_d;
      done      <= done_d;
      err       <= err_d;
      tx_start  <= start_d;
      tx_len    <= len_d;
      tx_port   <= port_d;
      src_sel   <= sel_d;
      frame_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Bench for udp_tx_scheduler: directed scenarios plus random requesters and sender,
// all outputs compared every cycle against a timestamp-based reference model.
module tb_udp_tx_scheduler;

  localparam int NUM_REQ = 4;
  localparam int MIN_LEN = 32;
  localparam int MAX_LEN = 1472;
  localparam int IFG     = 12;
  localparam int TIMEOUT = 4095;
  localparam int SEL_W   = 2;

  // ---------------- clock / reset / DUT ----------------
  logic                    sys_clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_REQ-1:0]      req = '0;
  logic [NUM_REQ*16-1:0]   req_len = '0;
  logic [NUM_REQ*16-1:0]   req_port = '0;
  logic                    tx_done = 1'b0;
  logic [NUM_REQ-1:0]      grant, done, err;
  logic                    tx_start;
  logic [15:0]             tx_len, tx_port;
  logic [SEL_W-1:0]        src_sel;
  logic [31:0]             frame_cnt;

  always #5 sys_clk = ~sys_clk;

  udp_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN),
    .IFG_CYCLES(IFG), .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .req(req), .req_len(req_len), .req_port(req_port),
    .grant(grant), .done(done), .err(err), .tx_start(tx_start), .tx_len(tx_len),
    .tx_port(tx_port), .src_sel(src_sel), .tx_done(tx_done), .frame_cnt(frame_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NUM_REQ-1:0] exp_grant = '0, exp_done = '0, exp_err = '0;
  logic               exp_start = 1'b0;
  logic [15:0]        exp_len = '0, exp_port = '0;
  logic [SEL_W-1:0]   exp_sel = '0;
  logic [31:0]        exp_cnt = '0;
  logic [SEL_W-1:0]   exp_q[$];

  int m_owner     = -1;  // requester currently sending, -1 when none
  int m_start     = 0;   // cycle in which tx_start is visible
  int m_idle_from = 0;   // first cycle in which requests may be sampled
  int m_ptr       = 0;

  // Predicts outputs for cycle t+1 from inputs sampled in cycle t.
  task automatic model_step(input int t, input logic [NUM_REQ-1:0] s_req,
                            input logic [NUM_REQ*16-1:0] s_len, input logic [NUM_REQ*16-1:0] s_port,
                            input logic s_done, input logic s_rst);
    int w;
    logic [15:0] l;
    exp_done  = '0;
    exp_err   = '0;
    exp_start = 1'b0;
    if (s_rst) begin
      exp_grant = '0; exp_len = '0; exp_port = '0; exp_sel = '0; exp_cnt = '0;
      m_owner = -1; m_idle_from = t + 1; m_ptr = 0;
      exp_q.delete();
    end else if (m_owner >= 0) begin
      if (s_done) begin
        exp_done = NUM_REQ'(1) << m_owner;
        exp_cnt  = exp_cnt + 1;
        exp_grant = '0; m_owner = -1; m_idle_from = t + 1 + IFG;
      end else if (t - m_start == TIMEOUT - 1) begin
        exp_err = NUM_REQ'(1) << m_owner;
        exp_grant = '0; m_owner = -1; m_idle_from = t + 1 + IFG;
      end
    end else if (t >= m_idle_from) begin
      w = -1;
      for (int k = NUM_REQ - 1; k >= 0; k--)
        if (((s_req >> ((m_ptr + k) % NUM_REQ)) & 1) != 0) w = (m_ptr + k) % NUM_REQ;
      if (w >= 0) begin
        m_ptr = (w + 1) % NUM_REQ;
        l = s_len[16*w +: 16];
        if (l >= MIN_LEN && l <= MAX_LEN) begin
          exp_grant = NUM_REQ'(1) << w;
          exp_start = 1'b1;
          exp_len   = l;
          exp_port  = s_port[16*w +: 16];
          exp_sel   = SEL_W'(w);
          m_owner   = w;
          m_start   = t + 1;
          exp_q.push_back(SEL_W'(w));
        end else begin
          exp_err = NUM_REQ'(1) << w;
        end
      end
    end
  endtask

  task automatic check_all();
    check("grant", 32'(grant), 32'(exp_grant));
    check("done", 32'(done), 32'(exp_done));
    check("err", 32'(err), 32'(exp_err));
    check("tx_start", 32'(tx_start), 32'(exp_start));
    check("tx_len", 32'(tx_len), 32'(exp_len));
    check("tx_port", 32'(tx_port), 32'(exp_port));
    check("src_sel", 32'(src_sel), 32'(exp_sel));
    check("frame_cnt", frame_cnt, exp_cnt);
    if (tx_start === 1'b1) begin
      if (exp_q.size() == 0) check("sb_extra_start", 32'd1, 32'd0);
      else check("sb_sel", 32'(src_sel), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic tick();
    logic [NUM_REQ-1:0]    s_req;
    logic [NUM_REQ*16-1:0] s_len, s_port;
    logic                  s_done, s_rst;
    s_req = req; s_len = req_len; s_port = req_port; s_done = tx_done; s_rst = rst;
    @(posedge sys_clk);
    model_step(cyc, s_req, s_len, s_port, s_done, s_rst);
    #1;
    cyc++;
    check_all();
  endtask

  // ---------------- drivers: sender and requesters ----------------
  int force_delay = -1;  // -1 random, -2 never complete, else fixed start->tx_done delay
  int done_at     = -1;
  int n_to = 0, n_co = 0;
  bit auto_drop = 1, rand_req = 0, spur_en = 1;

  function automatic logic [15:0] rand_len();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: return 16'($urandom_range(0, MIN_LEN - 1));
      1: return 16'($urandom_range(MAX_LEN + 1, 65535));
      2: return 16'(MIN_LEN);
      3: return 16'(MAX_LEN);
      4: return 16'(MAX_LEN + 1);
      default: return 16'($urandom_range(MIN_LEN + 1, MAX_LEN - 1));
    endcase
  endfunction

  task automatic drive();
    int r;
    if (exp_start) begin
      if (force_delay == -2) done_at = -1;
      else if (force_delay >= 0) done_at = cyc + force_delay;
      else begin
        r = $urandom_range(0, 15);
        if (r == 0 && n_to < 2) begin done_at = -1; n_to++; end
        else if (r == 1 && n_co < 3) begin done_at = cyc + TIMEOUT - 1; n_co++; end
        else done_at = cyc + $urandom_range(1, 120);
      end
    end
    if (m_owner < 0) done_at = -1;
    if (done_at >= 0 && cyc == done_at) tx_done = 1'b1;
    else tx_done = spur_en && m_owner < 0 && $urandom_range(0, 15) == 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (auto_drop && (((exp_done | exp_err) >> i) & 1) != 0) req[i] = 1'b0;
      else if (rand_req) begin
        if (!req[i] && $urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
          req_len[16*i +: 16]  = rand_len();
          req_port[16*i +: 16] = 16'($urandom);
        end else if (req[i] && m_owner == i && $urandom_range(0, 40) == 0) begin
          req[i] = 1'b0;
        end else if (m_owner == i && $urandom_range(0, 30) == 0) begin
          req_len[16*i +: 16]  = rand_len();
          req_port[16*i +: 16] = 16'($urandom);
        end
      end
    end
  endtask

  task automatic step();
    tick();
    drive();
  endtask

  // kind 0: tx_start, 1: done[idx], 2: err[idx]
  task automatic run_until(input string tag, input int kind, input int idx,
                           input int budget, output int when);
    when = -1;
    for (int n = 0; n < budget; n++) begin
      step();
      if ((kind == 0 && tx_start === 1'b1) ||
          (kind == 1 && ((done >> idx) & 1) === 1) ||
          (kind == 2 && ((err >> idx) & 1) === 1)) begin
        when = cyc;
        return;
      end
    end
    check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s, e, d, prev, c0;
    bit seen;

    // Reset state
    step(); step();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_len", 32'(tx_len), 32'd0);
    check("rst_cnt", frame_cnt, 32'd0);
    rst = 1'b0;

    // Single request, then gap enforcement before the same requester is re-granted
    force_delay = 100;
    req_len[16 +: 16] = 16'd64; req_port[16 +: 16] = 16'h8000; req[1] = 1'b1;
    step();
    check("single_grant", 32'(grant), 32'b0010);
    check("single_start", 32'(tx_start), 32'd1);
    check("single_len", 32'(tx_len), 32'd64);
    check("single_port", 32'(tx_port), 32'h8000);
    check("single_sel", 32'(src_sel), 32'd1);
    s = cyc;
    run_until("single_done", 1, 1, 200, d);
    check("single_done_lat", 32'(d - s), 32'd101);
    check("single_cnt", frame_cnt, 32'd1);
    req[1] = 1'b1;
    run_until("gap_start", 0, 0, 100, e);
    check("gap_len", 32'(e - d), 32'(IFG + 1));
    run_until("gap_done", 1, 1, 200, d);

    // All requesters held: strict rotation and spacing
    do_reset();
    auto_drop = 0; force_delay = 20;
    for (int i = 0; i < NUM_REQ; i++) req_len[16*i +: 16] = 16'(100 + 10 * i);
    req = '1;
    prev = 0;
    for (int j = 0; j < 5; j++) begin
      run_until("rr_start", 0, 0, 200, s);
      check("rr_seq", 32'(src_sel), 32'(j % NUM_REQ));
      if (j > 0) check("rr_spacing", 32'(s - prev), 32'(20 + IFG + 2));
      prev = s;
    end
    run_until("rr_done", 1, 0, 200, d);
    req = '0; auto_drop = 1;

    // Invalid lengths rotate the pointer without a start; boundary lengths accepted
    do_reset();
    req_len[32 +: 16] = 16'd20; req[2] = 1'b1;
    step();
    check("short_err", 32'(err), 32'b0100);
    check("short_start", 32'(tx_start), 32'd0);
    check("short_grant", 32'(grant), 32'd0);
    req_len[32 +: 16] = 16'd1500; req[2] = 1'b1;
    step();
    check("long_err", 32'(err), 32'b0100);
    check("long_start", 32'(tx_start), 32'd0);
    force_delay = 10;
    req_len[32 +: 16] = 16'd32; req_len[48 +: 16] = 16'd1472; req[3:2] = 2'b11;
    step();
    check("ptr3_grant", 32'(grant), 32'b1000);
    check("max_len", 32'(tx_len), 32'd1472);
    run_until("ptr3_done", 1, 3, 100, d);
    run_until("min_start", 0, 0, 100, s);
    check("min_sel", 32'(src_sel), 32'd2);
    check("min_len", 32'(tx_len), 32'd32);
    run_until("min_done", 1, 2, 100, d);

    // Watchdog expiry, then the next grant after the gap
    force_delay = -2;
    c0 = 32'(frame_cnt);
    req_len[0 +: 16] = 16'd200; req[0] = 1'b1;
    run_until("to_start", 0, 0, 100, s);
    req_len[16 +: 16] = 16'd300; req[1] = 1'b1;
    run_until("to_err", 2, 0, TIMEOUT + 20, e);
    check("to_latency", 32'(e - s), 32'(TIMEOUT));
    check("to_grant", 32'(grant), 32'd0);
    check("to_done", 32'(done), 32'd0);
    check("to_cnt", frame_cnt, 32'(c0));
    force_delay = 10;
    run_until("to_next", 0, 0, 100, s);
    check("to_next_at", 32'(s - e), 32'(IFG + 1));
    check("to_next_sel", 32'(src_sel), 32'd1);
    run_until("to_next_done", 1, 1, 100, d);

    // tx_done on the watchdog's last cycle completes the frame
    force_delay = TIMEOUT - 1;
    req_len[32 +: 16] = 16'd500; req[2] = 1'b1;
    run_until("co_start", 0, 0, 100, s);
    c0 = 32'(frame_cnt);
    run_until("co_done", 1, 2, TIMEOUT + 20, d);
    check("co_latency", 32'(d - s), 32'(TIMEOUT));
    check("co_err", 32'(err), 32'd0);
    check("co_cnt", frame_cnt, 32'(c0 + 1));

    // Owner withdraws its request mid-frame
    force_delay = 30;
    req_len[48 +: 16] = 16'd64; req[3] = 1'b1;
    run_until("drop_start", 0, 0, 100, s);
    repeat (5) step();
    req[3] = 1'b0;
    run_until("drop_done", 1, 3, 100, d);
    check("drop_latency", 32'(d - s), 32'd31);

    // Reset in the middle of a frame
    force_delay = -2;
    req[1] = 1'b1;
    run_until("mid_start", 0, 0, 100, s);
    repeat (5) step();
    do_reset();
    check("mid_grant", 32'(grant), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_err", 32'(err), 32'd0);
    check("mid_cnt", frame_cnt, 32'd0);
    check("mid_sel", 32'(src_sel), 32'd0);
    force_delay = 10;
    req_len[0 +: 16] = 16'd100; req_len[48 +: 16] = 16'd100; req = 4'b1001;
    step();
    check("mid_first", 32'(grant), 32'b0001);
    run_until("mid_d0", 1, 0, 100, d);
    run_until("mid_d3", 1, 3, 100, d);

    // Spurious tx_done while nothing is being sent
    c0 = 32'(frame_cnt);
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (done !== '0) seen = 1;
    end
    check("spur_done", 32'(seen), 32'd0);
    check("spur_cnt", frame_cnt, 32'(c0));

    // Random traffic
    force_delay = -1; rand_req = 1;
    repeat (12000) step();
    rand_req = 0; req = '0;
    repeat (TIMEOUT + IFG + 20) step();
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
